fmod_unit_arbiter: RTL and testbench

- Shares one generic_fmod_double core (ap_ctrl_hs interface) between NUM_REQ independent requesters in the RNG datapath.
- Accepts requests by valid/ready and grants them round-robin.
- Drives the core's ap_start/ap_ready/ap_done handshake, then returns each result to the requester that issued it.
- Sits between the RNG stage logic and the fmod core instance, one operation in flight at a time.

---
 rtl/fmod_unit_arbiter_pkg.sv | 24 ++
 rtl/fmod_unit_arbiter_if.sv | 45 ++++
 rtl/fmod_unit_arbiter_rr_arbiter.sv | 57 +++++
 rtl/fmod_unit_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_fmod_unit_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmod_unit_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fmod_arb_pkg
// Shared types and constants for the fmod unit arbiter:
//   arb_state_e  - arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   FMOD_DATA_W  - native operand/result width of the fmod core (double)
//   idx_w(n)     - index width for n items, never less than 1
// ---------------------------------------------------------------------------
package fmod_arb_pkg;

  localparam int FMOD_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  function automatic int idx_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage : fmod_arb_pkg

// File: rtl/fmod_unit_arbiter_if.sv
// ---------------------------------------------------------------------------
// fmod_core_if
// ap_ctrl_hs handshake plus operand/result buses between the arbiter and a
// generic_fmod_double core.
//   master : arbiter side (drives start and operands, receives ready/done/result)
//   slave  : core side
// Signals:
//   fmod_ap_start   - start request, held until ready is sampled
//   fmod_ap_ready   - core has taken the operands
//   fmod_ap_done    - one-cycle pulse, fmod_ap_return valid
//   fmod_x, fmod_y  - dividend / divisor
//   fmod_ap_return  - result
// ---------------------------------------------------------------------------
interface fmod_core_if
  import fmod_arb_pkg::*;
#(
  parameter int DATA_W = FMOD_DATA_W
) ();

  logic              fmod_ap_start;
  logic              fmod_ap_ready;
  logic              fmod_ap_done;
  logic [DATA_W-1:0] fmod_x;
  logic [DATA_W-1:0] fmod_y;
  logic [DATA_W-1:0] fmod_ap_return;

  modport master (
    output fmod_ap_start,
    output fmod_x,
    output fmod_y,
    input  fmod_ap_ready,
    input  fmod_ap_done,
    input  fmod_ap_return
  );

  modport slave (
    input  fmod_ap_start,
    input  fmod_x,
    input  fmod_y,
    output fmod_ap_ready,
    output fmod_ap_done,
    output fmod_ap_return
  );

endinterface : fmod_core_if

// File: rtl/fmod_unit_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set bit of req found when
// scanning from last+1 upward, wrapping modulo N.
// Ports:
//   req  [N-1:0]         - request vector
//   last [idx_w(N)-1:0]  - index granted most recently
//   gnt  [N-1:0]         - one-hot grant (all zero when req is zero)
//   idx  [idx_w(N)-1:0]  - encoded grant index (0 when req is zero)
// ---------------------------------------------------------------------------
module rr_arbiter
  import fmod_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   last,
  output logic [N-1:0]          gnt,
  output logic [idx_w(N)-1:0]   idx
);

  localparam int IW = idx_w(N);

  // Two copies of req side by side: masking off everything at or below 'last'
  // leaves the lowest surviving bit as the round-robin winner, and the upper
  // copy supplies the wrapped-around candidates.
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic           found;

  assign dbl = {req, req};

  generate
    for (genvar gi = 0; gi < 2*N; gi++) begin : g_mask
      assign masked[gi] = dbl[gi] & (gi > int'(last));
    end
  endgenerate

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      if (masked[j] && !found) begin
        found = 1'b1;
        if (j >= N) begin
          gnt[j-N] = 1'b1;
          idx      = IW'(j - N);
        end else begin
          gnt[j]   = 1'b1;
          idx      = IW'(j);
        end
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/fmod_unit_arbiter.sv
// ---------------------------------------------------------------------------
// fmod_unit_arbiter
// Shares one ap_ctrl_hs fmod core between NUM_REQ requesters. Requests are
// accepted by valid/ready, granted round-robin, run one at a time through the
// core and the result is returned to the requester that issued it.
// Ports:
//   ap_clk, ap_rst_n     - clock, asynchronous active-low reset
//   req_valid/req_ready  - per-requester request handshake (ready one-hot)
//   req_x, req_y         - packed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready  - per-requester result handshake (valid one-hot)
//   rsp_data             - shared result bus, stable while rsp_valid is high
//   fmod                 - core handshake and operand/result buses (master)
//   busy                 - FSM is not IDLE
//   grant_id             - index of the current owner
//   proto_err            - sticky, core handshake pulse seen in a wrong state
// Optional build macro FMOD_ARB_PERF_CNT_EN adds:
//   perf_ops   - completed response handshakes (wraps at 2^32)
//   perf_stall - busy cycles with another requester waiting (wraps at 2^32)
// ---------------------------------------------------------------------------
module fmod_unit_arbiter
  import fmod_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = FMOD_DATA_W
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_x,
  input  logic [NUM_REQ*DATA_W-1:0]   req_y,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  fmod_core_if.master                 fmod,
  output logic                        busy,
  output logic [idx_w(NUM_REQ)-1:0]   grant_id,
  output logic                        proto_err
`ifdef FMOD_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_ops,
  output logic [31:0]                 perf_stall
`endif
);

  localparam int IW = idx_w(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              proto_err_q, proto_err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic [NUM_REQ-1:0] owner_oh;
  logic               rsp_hs;
  logic               start;

  logic [DATA_W-1:0] x_slice [NUM_REQ];
  logic [DATA_W-1:0] y_slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign x_slice[gi]  = req_x[gi*DATA_W +: DATA_W];
      assign y_slice[gi]  = req_y[gi*DATA_W +: DATA_W];
      assign owner_oh[gi] = (grant_id_q == IW'(gi));
    end
  endgenerate

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req  (req_valid),
    .last (last_grant_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign rsp_hs = |(rsp_ready & owner_oh);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    x_d          = x_q;
    y_d          = y_q;
    rsp_data_d   = rsp_data_q;
    proto_err_d  = proto_err_q;
    req_ready    = '0;
    rsp_valid    = '0;
    start        = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready    = arb_gnt;
          x_d          = x_slice[arb_idx];
          y_d          = y_slice[arb_idx];
          grant_id_d   = arb_idx;
          last_grant_d = arb_idx;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        start = 1'b1;
        if (fmod.fmod_ap_ready) begin
          // A zero-latency core may finish in the accepting cycle.
          if (fmod.fmod_ap_done) begin
            rsp_data_d = fmod.fmod_ap_return;
            state_d    = RESP;
          end else begin
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (fmod.fmod_ap_done) begin
          rsp_data_d = fmod.fmod_ap_return;
          state_d    = RESP;
        end
      end
      RESP: begin
        rsp_valid = owner_oh;
        // Returning to IDLE costs one cycle before the next grant can fire.
        if (rsp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fmod.fmod_ap_done && !(state_q == ISSUE || state_q == WAIT)) begin
      proto_err_d = 1'b1;
    end
    if (fmod.fmod_ap_ready && (state_q != ISSUE)) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      rsp_data_q   <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      x_q          <= x_d;
      y_q          <= y_d;
      rsp_data_q   <= rsp_data_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign fmod.fmod_ap_start = start;
  assign fmod.fmod_x        = x_q;
  assign fmod.fmod_y        = y_q;
  assign rsp_data           = rsp_data_q;
  assign busy               = (state_q != IDLE);
  assign grant_id           = grant_id_q;
  assign proto_err          = proto_err_q;

`ifdef FMOD_ARB_PERF_CNT_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if ((state_q == RESP) && rsp_hs) begin
      perf_ops_d = perf_ops_q + 32'd1;
    end
    // Someone other than the current owner is left waiting.
    if ((state_q != IDLE) && |(req_valid & ~owner_oh)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule : fmod_unit_arbiter

// File: tb/tb_fmod_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fmod_unit_arbiter
// Directed and randomized bench for fmod_unit_arbiter with a behavioural fmod
// core of programmable latency and a round-robin reference model.
// Honours FMOD_ARB_PERF_CNT_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_fmod_unit_arbiter;
  import fmod_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;

  logic                ap_clk;
  logic                ap_rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*DW-1:0]     req_x;
  logic [N*DW-1:0]     req_y;
  logic [N-1:0]        rsp_valid;
  logic [N-1:0]        rsp_ready;
  logic [DW-1:0]       rsp_data;
  logic                busy;
  logic [idx_w(N)-1:0] grant_id;
  logic                proto_err;
`ifdef FMOD_ARB_PERF_CNT_EN
  logic [31:0]         perf_ops;
  logic [31:0]         perf_stall;
`endif

  fmod_core_if #(.DATA_W(DW)) cif ();

  // Core model outputs plus an injection path for protocol-error pulses.
  logic          core_ready;
  logic          core_done;
  logic [DW-1:0] core_ret;
  logic          inj_done;
  int            lat;

  assign cif.fmod_ap_ready  = core_ready;
  assign cif.fmod_ap_done   = core_done | inj_done;
  assign cif.fmod_ap_return = core_ret;

  logic [DW-1:0] ox [N];
  logic [DW-1:0] oy [N];

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < N; i++) begin
      req_x[i*DW +: DW] = ox[i];
      req_y[i*DW +: DW] = oy[i];
    end
  end

  fmod_unit_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .fmod      (cif),
    .busy      (busy),
    .grant_id  (grant_id),
    .proto_err (proto_err)
`ifdef FMOD_ARB_PERF_CNT_EN
    ,
    .perf_ops  (perf_ops),
    .perf_stall(perf_stall)
`endif
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // ---------------- reference helpers ----------------
  function automatic logic [63:0] fmod_bits(input logic [63:0] xb, input logic [63:0] yb);
    real xr, yr;
    xr = $bitstoreal(xb);
    yr = $bitstoreal(yb);
    return $realtobits(xr - yr * real'($rtoi(xr / yr)));
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Next owner: first valid requester after the last one served, wrapping.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // ---------------- behavioural fmod core ----------------
  int            core_cnt;
  logic [DW-1:0] core_res;

  initial begin
    core_ready = 1'b0;
    core_done  = 1'b0;
    core_ret   = '0;
    core_cnt   = -1;
    core_res   = '0;
    forever begin
      @(negedge ap_clk);
      core_ready = 1'b0;
      core_done  = 1'b0;
      if (!ap_rst_n) begin
        core_cnt = -1;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done = 1'b1;
          core_ret  = core_res;
          core_cnt  = -1;
        end
      end else if (cif.fmod_ap_start) begin
        core_res   = fmod_bits(cif.fmod_x, cif.fmod_y);
        core_ready = 1'b1;
        if (lat == 0) begin
          core_done = 1'b1;
          core_ret  = core_res;
        end else begin
          core_cnt = lat;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp;
  int n_err;
  int model_last;
  int ops_total;
  int gq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic arm(input int i);
    int xi, yi;
    xi    = int'($urandom_range(0, 800)) - 400;
    yi    = int'($urandom_range(1, 40));
    ox[i] = $realtobits(real'(xi) / 4.0);
    oy[i] = $realtobits(($urandom_range(0, 1) == 1 ? -1.0 : 1.0) * real'(yi) / 4.0);
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n   = 1'b1;
    model_last = N - 1;
    ops_total  = 0;
  endtask

  task automatic wait_rsp(input string tag);
    int k;
    k = 0;
    while (rsp_valid == '0 && k < 50) begin
      @(negedge ap_clk);
      k++;
    end
    chk(tag, 64'(k < 50), 64'd1);
  endtask

  // Keeps every requester in 'mask' asking, re-arming it with fresh operands
  // once served, until n_ops results have been handed back.
  task automatic run_ops(input int n_ops, input logic [N-1:0] mask, input bit rand_bp);
    int            done_ops, cyc, owner, w, rearm;
    bit            just_acc;
    logic [DW-1:0] exp_res, exp_x, exp_y;
    done_ops = 0;
    cyc      = 0;
    owner    = -1;
    rearm    = -1;
    just_acc = 1'b0;
    exp_res  = '0;
    exp_x    = '0;
    exp_y    = '0;
    for (int i = 0; i < N; i++) if (mask[i]) arm(i);
    req_valid = mask;
    while (done_ops < n_ops && cyc < 4000) begin
      #1;
      if (!busy && req_valid != '0) begin
        w = rr_pick(req_valid, model_last);
        chk("req_ready_grant", 64'(req_ready), 64'(oh(w)));
        owner      = w;
        model_last = w;
        rearm      = w;
        just_acc   = 1'b1;
        exp_x      = ox[w];
        exp_y      = oy[w];
        exp_res    = fmod_bits(ox[w], oy[w]);
        gq.push_back(w);
      end else begin
        chk("req_ready_idle", 64'(req_ready), 64'd0);
      end
      @(negedge ap_clk);
      cyc++;
      if (just_acc) begin
        chk("start_after_accept", 64'(cif.fmod_ap_start), 64'd1);
        chk("fmod_x", cif.fmod_x, exp_x);
        chk("fmod_y", cif.fmod_y, exp_y);
        chk("grant_id", 64'(grant_id), 64'(owner));
        just_acc = 1'b0;
      end
      if (rearm >= 0) begin
        arm(rearm);
        rearm = -1;
      end
      rsp_ready = rand_bp ? N'($urandom) : '1;
      if (rsp_valid != '0) begin
        chk("rsp_valid_owner", 64'(rsp_valid), 64'(oh(owner)));
        chk("rsp_data", rsp_data, exp_res);
        if (rsp_ready[owner]) begin
          done_ops++;
          ops_total++;
          $display("op %0d: req=%0d x=%h y=%h rsp=%h", ops_total, owner, exp_x, exp_y, rsp_data);
        end
      end
    end
    chk("run_ops_done", 64'(done_ops), 64'(n_ops));
    @(negedge ap_clk);
    req_valid = '0;
    rsp_ready = '0;
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] exp_r;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    ops_total  = 0;
    model_last = N - 1;
    lat        = 1;
    inj_done   = 1'b0;
    req_valid  = '0;
    rsp_ready  = '0;
    for (int i = 0; i < N; i++) begin
      ox[i] = '0;
      oy[i] = '0;
    end
    ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_start", 64'(cif.fmod_ap_start), 64'd0);
    chk("rst_fmod_x", cif.fmod_x, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
`ifdef FMOD_ARB_PERF_CNT_EN
    chk("rst_perf_ops", 64'(perf_ops), 64'd0);
`endif
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Single request, core latency 3: 7.5 fmod 2.0 = 1.5
    lat       = 3;
    ox[0]     = 64'h401E000000000000;
    oy[0]     = 64'h4000000000000000;
    req_valid = 4'b0001;
    #1;
    chk("t1_req_ready", 64'(req_ready), 64'b0001);
    model_last = 0;
    @(negedge ap_clk);
    req_valid = '0;
    chk("t1_start", 64'(cif.fmod_ap_start), 64'd1);
    chk("t1_fmod_x", cif.fmod_x, 64'h401E000000000000);
    chk("t1_fmod_y", cif.fmod_y, 64'h4000000000000000);
    repeat (3) begin
      @(negedge ap_clk);
      chk("t1_start_low", 64'(cif.fmod_ap_start), 64'd0);
      chk("t1_no_rsp_yet", 64'(rsp_valid), 64'd0);
    end
    @(negedge ap_clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'b0001);
    chk("t1_rsp_data", rsp_data, 64'h3FF8000000000000);
    rsp_ready = 4'b0001;
    ops_total++;
    $display("op %0d: req=0 x=%h y=%h rsp=%h", ops_total, ox[0], oy[0], rsp_data);
    @(negedge ap_clk);
    rsp_ready = '0;
    chk("t1_idle", 64'(busy), 64'd0);

    // Round-robin from a fresh reset: all four held high for 8 ops
    do_reset();
    lat = 1;
    gq.delete();
    run_ops(8, 4'b1111, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("rr_order", 64'(gq.size() > i ? gq[i] : -1), 64'(i % 4));
    end

    // Zero-latency core: ISSUE goes straight to RESP
    lat   = 0;
    arm(2);
    req_valid = 4'b0100;
    #1;
    chk("t3_req_ready", 64'(req_ready), 64'(oh(rr_pick(4'b0100, model_last))));
    model_last = 2;
    exp_r      = fmod_bits(ox[2], oy[2]);
    @(negedge ap_clk);
    req_valid = '0;
    chk("t3_start", 64'(cif.fmod_ap_start), 64'd1);
    @(negedge ap_clk);
    chk("t3_rsp_valid", 64'(rsp_valid), 64'b0100);
    chk("t3_rsp_data", rsp_data, exp_r);
    rsp_ready = 4'b0100;
    ops_total++;
    $display("op %0d: req=2 x=%h y=%h rsp=%h", ops_total, ox[2], oy[2], rsp_data);
    @(negedge ap_clk);
    rsp_ready = '0;
    chk("t3_idle", 64'(busy), 64'd0);

    // Backpressure on requester 1 while requester 3 waits
    lat = 1;
    arm(1);
    req_valid = 4'b0010;
    #1;
    chk("t4_req_ready", 64'(req_ready), 64'b0010);
    model_last = 1;
    exp_r      = fmod_bits(ox[1], oy[1]);
    @(negedge ap_clk);
    req_valid = '0;
    wait_rsp("t4_rsp_arrives");
    arm(3);
    req_valid = 4'b1000;
    repeat (5) begin
      #1;
      chk("t4_no_new_ready", 64'(req_ready), 64'd0);
      @(negedge ap_clk);
      chk("t4_rsp_valid_hold", 64'(rsp_valid), 64'b0010);
      chk("t4_rsp_data_hold", rsp_data, exp_r);
    end
    rsp_ready = 4'b0010;
    ops_total++;
    $display("op %0d: req=1 x=%h y=%h rsp=%h", ops_total, ox[1], oy[1], rsp_data);
    @(negedge ap_clk);
    rsp_ready = '0;
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_next_ready", 64'(req_ready), 64'b1000);
    // Requester 3 withdraws before the edge and must not be served.
    req_valid = '0;
    @(negedge ap_clk);
    chk("t4_withdrawn", 64'(busy), 64'd0);

    // Randomized mixes with random response backpressure
    lat = 2;
    for (int k = 0; k < 4; k++) begin
      lat = int'($urandom_range(0, 4));
      run_ops(6, N'($urandom_range(1, 15)), 1'b1);
    end
    chk("rand_proto_err", 64'(proto_err), 64'd0);

    // Reset in the middle of WAIT
    lat = 20;
    arm(1);
    req_valid = 4'b0010;
    #1;
    chk("t6_req_ready", 64'(req_ready), 64'(oh(rr_pick(4'b0010, model_last))));
    @(negedge ap_clk);
    req_valid = '0;
    @(negedge ap_clk);
    chk("t6_in_wait", 64'(busy), 64'd1);
    chk("t6_start_low", 64'(cif.fmod_ap_start), 64'd0);
    ap_rst_n = 1'b0;
    #1;
    chk("t6_async_busy", 64'(busy), 64'd0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_proto_err", 64'(proto_err), 64'd0);
    chk("t6_grant_id", 64'(grant_id), 64'd0);
    ap_rst_n   = 1'b1;
    model_last = N - 1;
    ops_total  = 0;
    lat        = 2;
    arm(0);
    arm(2);
    req_valid = 4'b0101;
    #1;
    chk("t6_first_grant_0", 64'(req_ready), 64'b0001);
    model_last = 0;
    exp_r      = fmod_bits(ox[0], oy[0]);
    @(negedge ap_clk);
    req_valid = '0;
    wait_rsp("t6_rsp_arrives");
    chk("t6_rsp_valid_0", 64'(rsp_valid), 64'b0001);
    chk("t6_rsp_data", rsp_data, exp_r);
    rsp_ready = 4'b0001;
    ops_total++;
    $display("op %0d: req=0 x=%h y=%h rsp=%h", ops_total, ox[0], oy[0], rsp_data);
    @(negedge ap_clk);
    rsp_ready = '0;

    // Spurious done while idle
    inj_done = 1'b1;
    @(negedge ap_clk);
    inj_done = 1'b0;
    chk("t7_proto_err", 64'(proto_err), 64'd1);
    chk("t7_no_rsp", 64'(rsp_valid), 64'd0);
    chk("t7_idle", 64'(busy), 64'd0);
    lat = 1;
    run_ops(3, 4'b1111, 1'b1);
    chk("t7_proto_sticky", 64'(proto_err), 64'd1);
`ifdef FMOD_ARB_PERF_CNT_EN
    chk("perf_ops", 64'(perf_ops), 64'(ops_total));
    $display("perf_stall=%0d", perf_stall);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fmod_unit_arbiter
